// File: rtl/alu_instr_sequencer.sv
// Hardwired control unit: sequences fetch (T0-T2) and register-register ALU execute (T3-T5)
// strobes for the bus-based datapath, with memory ready handshake, timeout and illegal-op trap.
//
// state  | meaning
// S_IDLE | no strobes; waits for Run
// S_T0   | PC to MAR, PC+1 into Z
// S_T1   | Z to PC (first cycle), memory read into MDR; holds until Mem_ready
// S_T2   | MDR to IR
// S_T3   | decode; Rb onto bus into Y (ALU ops)
// S_T4   | Rc onto bus, ALU op into Z
// S_T5   | Z into Ra; instruction retires
// S_HALT | Halted; left only through reset
module alu_instr_sequencer #(
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 16,
  parameter int ALU_CTRL_W  = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Run,
  input  logic                  Mem_ready,
  input  logic [DATA_W-1:0]     IR_data,
  output logic                  PCout,
  output logic                  ZLOout,
  output logic                  MDRout,
  output logic                  MARin,
  output logic                  PCin,
  output logic                  MDRin,
  output logic                  IRin,
  output logic                  Yin,
  output logic                  Zin,
  output logic                  IncrementPC,
  output logic                  Read,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic [NUM_REGS-1:0]   Rin,
  output logic [NUM_REGS-1:0]   Rout,
  output logic                  Halted,
  output logic                  Illegal_op,
  output logic                  Bus_error,
  output logic [CNT_W-1:0]      Instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT
  } state_t;

  localparam logic [4:0] OP_ALU_FIRST = 5'b00011;
  localparam logic [4:0] OP_ALU_LAST  = 5'b01011;
  localparam logic [4:0] OP_NOP       = 5'b11010;
  localparam logic [4:0] OP_HALT      = 5'b11011;
  localparam logic [4:0] REG_LIMIT    = 5'(NUM_REGS);
  localparam logic [7:0] TMO_LOAD     = 8'(MEM_TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;

  logic [4:0] op;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic       is_alu;
  logic       is_nop;
  logic       is_halt;
  logic       regs_ok;
  logic       illegal;
  logic       unused_ir_bits;

  assign op      = IR_data[31:27];
  assign ra      = IR_data[26:23];
  assign rb      = IR_data[22:19];
  assign rc      = IR_data[18:15];
  assign is_alu  = (op >= OP_ALU_FIRST) && (op <= OP_ALU_LAST);
  assign is_nop  = (op == OP_NOP);
  assign is_halt = (op == OP_HALT);
  assign regs_ok = ({1'b0, ra} < REG_LIMIT) && ({1'b0, rb} < REG_LIMIT) &&
                   ({1'b0, rc} < REG_LIMIT);
  // Register fields only matter for ALU ops; nop/halt ignore them.
  assign illegal = !(is_nop || is_halt || (is_alu && regs_ok));
  assign unused_ir_bits = ^IR_data[14:0];

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [3:0] idx);
    reg_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Outputs are written together with the state they belong to, so they are
  // valid for exactly the cycles the state register holds that state.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      PCout       <= 1'b0;
      ZLOout      <= 1'b0;
      MDRout      <= 1'b0;
      MARin       <= 1'b0;
      PCin        <= 1'b0;
      MDRin       <= 1'b0;
      IRin        <= 1'b0;
      Yin         <= 1'b0;
      Zin         <= 1'b0;
      IncrementPC <= 1'b0;
      Read        <= 1'b0;
      ALUControl  <= '0;
      Rin         <= '0;
      Rout        <= '0;
      Halted      <= 1'b0;
      Illegal_op  <= 1'b0;
      Bus_error   <= 1'b0;
      Instr_count <= '0;
    end else begin
      PCout       <= 1'b0;
      ZLOout      <= 1'b0;
      MDRout      <= 1'b0;
      MARin       <= 1'b0;
      PCin        <= 1'b0;
      MDRin       <= 1'b0;
      IRin        <= 1'b0;
      Yin         <= 1'b0;
      Zin         <= 1'b0;
      IncrementPC <= 1'b0;
      Read        <= 1'b0;
      ALUControl  <= '0;
      Rin         <= '0;
      Rout        <= '0;
      Halted      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Run) begin
            state       <= S_T0;
            PCout       <= 1'b1;
            MARin       <= 1'b1;
            IncrementPC <= 1'b1;
            Zin         <= 1'b1;
          end
        end
        S_T0: begin
          state    <= S_T1;
          wait_cnt <= TMO_LOAD;
          ZLOout   <= 1'b1;
          PCin     <= 1'b1;
          Read     <= 1'b1;
          MDRin    <= 1'b1;
        end
        S_T1: begin
          if (Mem_ready) begin
            state  <= S_T2;
            MDRout <= 1'b1;
            IRin   <= 1'b1;
          end else if (wait_cnt == 8'd0) begin
            state     <= S_HALT;
            Halted    <= 1'b1;
            Bus_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
            ZLOout   <= 1'b1;
            Read     <= 1'b1;
            MDRin    <= 1'b1;
          end
        end
        S_T2: begin
          state <= S_T3;
          if (is_alu && regs_ok) begin
            Rout <= reg_onehot(rb);
            Yin  <= 1'b1;
          end
        end
        S_T3: begin
          if (illegal) begin
            state      <= S_HALT;
            Halted     <= 1'b1;
            Illegal_op <= 1'b1;
          end else if (is_halt) begin
            state  <= S_HALT;
            Halted <= 1'b1;
          end else if (is_nop) begin
            Instr_count <= Instr_count + CNT_W'(1);
            if (Run) begin
              state       <= S_T0;
              PCout       <= 1'b1;
              MARin       <= 1'b1;
              IncrementPC <= 1'b1;
              Zin         <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            state      <= S_T4;
            Rout       <= reg_onehot(rc);
            ALUControl <= ALU_CTRL_W'(op);
            Zin        <= 1'b1;
          end
        end
        S_T4: begin
          state  <= S_T5;
          ZLOout <= 1'b1;
          Rin    <= reg_onehot(ra);
        end
        S_T5: begin
          Instr_count <= Instr_count + CNT_W'(1);
          if (Run) begin
            state       <= S_T0;
            PCout       <= 1'b1;
            MARin       <= 1'b1;
            IncrementPC <= 1'b1;
            Zin         <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_HALT: begin
          Halted <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed bench for alu_instr_sequencer: a default instance plus a NUM_REGS=8 / CNT_W=4
// instance sharing the same inputs; all expected values are hand-computed constants.
module tb_alu_instr_sequencer;

  logic        Clock;
  logic        Reset;
  logic        Run;
  logic        Mem_ready;
  logic [31:0] IR_data;

  logic        PCout, ZLOout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin, IncrementPC, Read;
  logic [4:0]  ALUControl;
  logic [15:0] Rin, Rout;
  logic        Halted, Illegal_op, Bus_error;
  logic [15:0] Instr_count;

  logic        s_PCout, s_ZLOout, s_MDRout, s_MARin, s_PCin, s_MDRin, s_IRin, s_Yin, s_Zin;
  logic        s_IncrementPC, s_Read;
  logic [4:0]  s_ALUControl;
  logic [7:0]  s_Rin, s_Rout;
  logic        s_Halted, s_Illegal_op, s_Bus_error;
  logic [3:0]  s_Instr_count;

  int n_cmp = 0;
  int n_err = 0;

  // {PCout,ZLOout,MDRout,MARin,PCin,MDRin,IRin,Yin,Zin,IncrementPC,Read,Halted}
  logic [11:0] strobes;
  assign strobes = {PCout, ZLOout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin,
                    IncrementPC, Read, Halted};

  localparam logic [11:0] ST_IDLE  = 12'h000;
  localparam logic [11:0] ST_T0    = 12'h90C;
  localparam logic [11:0] ST_T1_1  = 12'h4C2;
  localparam logic [11:0] ST_T1_N  = 12'h442;
  localparam logic [11:0] ST_T2    = 12'h220;
  localparam logic [11:0] ST_T3    = 12'h010;
  localparam logic [11:0] ST_T4    = 12'h008;
  localparam logic [11:0] ST_T5    = 12'h400;
  localparam logic [11:0] ST_HALT  = 12'h001;

  alu_instr_sequencer dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .Mem_ready(Mem_ready), .IR_data(IR_data),
    .PCout(PCout), .ZLOout(ZLOout), .MDRout(MDRout), .MARin(MARin), .PCin(PCin),
    .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .IncrementPC(IncrementPC),
    .Read(Read), .ALUControl(ALUControl), .Rin(Rin), .Rout(Rout), .Halted(Halted),
    .Illegal_op(Illegal_op), .Bus_error(Bus_error), .Instr_count(Instr_count)
  );

  alu_instr_sequencer #(.NUM_REGS(8), .CNT_W(4)) dut_small (
    .Clock(Clock), .Reset(Reset), .Run(Run), .Mem_ready(Mem_ready), .IR_data(IR_data),
    .PCout(s_PCout), .ZLOout(s_ZLOout), .MDRout(s_MDRout), .MARin(s_MARin), .PCin(s_PCin),
    .MDRin(s_MDRin), .IRin(s_IRin), .Yin(s_Yin), .Zin(s_Zin), .IncrementPC(s_IncrementPC),
    .Read(s_Read), .ALUControl(s_ALUControl), .Rin(s_Rin), .Rout(s_Rout), .Halted(s_Halted),
    .Illegal_op(s_Illegal_op), .Bus_error(s_Bus_error), .Instr_count(s_Instr_count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset = 1'b0; Run = 1'b0; Mem_ready = 1'b0; IR_data = 32'h0;
    tick(); tick();
    check("reset_strobes", {20'h0, strobes}, {20'h0, ST_IDLE});
    check("reset_count", {16'h0, Instr_count}, 32'h0);
    check("reset_flags", {30'h0, Illegal_op, Bus_error}, 32'h0);

    // and R1,R3,R5 with memory ready immediately
    Reset = 1'b1; Run = 1'b1; Mem_ready = 1'b1; IR_data = 32'h289A8000;
    tick(); check("and_t0", {20'h0, strobes}, {20'h0, ST_T0});
    tick(); check("and_t1", {20'h0, strobes}, {20'h0, ST_T1_1});
    tick(); check("and_t2", {20'h0, strobes}, {20'h0, ST_T2});
    tick(); check("and_t3", {20'h0, strobes}, {20'h0, ST_T3});
            check("and_t3_rout", {16'h0, Rout}, 32'h0008);
    tick(); check("and_t4", {20'h0, strobes}, {20'h0, ST_T4});
            check("and_t4_rout", {16'h0, Rout}, 32'h0020);
            check("and_t4_alu", {27'h0, ALUControl}, 32'h05);
    Run = 1'b0;
    tick(); check("and_t5", {20'h0, strobes}, {20'h0, ST_T5});
            check("and_t5_rin", {16'h0, Rin}, 32'h0002);
            check("and_t5_rout", {16'h0, Rout}, 32'h0);
            check("and_t5_count", {16'h0, Instr_count}, 32'h0);
    tick(); check("and_idle", {20'h0, strobes}, {20'h0, ST_IDLE});
            check("and_count", {16'h0, Instr_count}, 32'h1);

    // reset in the middle of T4
    Run = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    check("pre_rst_t4", {20'h0, strobes}, {20'h0, ST_T4});
    Reset = 1'b0; Run = 1'b0;
    tick(); check("rst_t4_strobes", {20'h0, strobes}, {20'h0, ST_IDLE});
            check("rst_t4_rout", {16'h0, Rout}, 32'h0);
            check("rst_t4_alu", {27'h0, ALUControl}, 32'h0);
            check("rst_t4_count", {16'h0, Instr_count}, 32'h0);
    Reset = 1'b1;
    tick(); check("rst_stays_idle", {20'h0, strobes}, {20'h0, ST_IDLE});

    // shra R1,R3,R5 with Mem_ready arriving in the third T1 cycle
    Run = 1'b1; Mem_ready = 1'b0; IR_data = 32'h409A8000;
    tick(); check("shra_t0", {20'h0, strobes}, {20'h0, ST_T0});
    tick(); check("shra_t1a", {20'h0, strobes}, {20'h0, ST_T1_1});
    tick(); check("shra_t1b", {20'h0, strobes}, {20'h0, ST_T1_N});
    tick(); check("shra_t1c", {20'h0, strobes}, {20'h0, ST_T1_N});
    Mem_ready = 1'b1;
    tick(); check("shra_t2", {20'h0, strobes}, {20'h0, ST_T2});
    tick(); check("shra_t3_rout", {16'h0, Rout}, 32'h0008);
    Run = 1'b0;
    tick(); check("shra_t4_alu", {27'h0, ALUControl}, 32'h08);
    tick(); check("shra_t5_rin", {16'h0, Rin}, 32'h0002);
    tick(); check("shra_count", {16'h0, Instr_count}, 32'h1);

    // illegal opcode 11111 halts and stays halted with Run high
    Run = 1'b1; IR_data = 32'hF8000000;
    tick(); tick(); tick(); tick();
    check("ill_t3_strobes", {20'h0, strobes}, {20'h0, 12'h000});
    tick(); check("ill_halt", {20'h0, strobes}, {20'h0, ST_HALT});
            check("ill_flag", {31'h0, Illegal_op}, 32'h1);
    tick(); tick(); tick();
    check("ill_stays", {20'h0, strobes}, {20'h0, ST_HALT});
    check("ill_flags", {30'h0, Illegal_op, Bus_error}, 32'h2);
    check("ill_count", {16'h0, Instr_count}, 32'h1);

    // memory never ready: timeout after 15 T1 cycles
    Reset = 1'b0; tick(); Reset = 1'b1;
    Run = 1'b1; Mem_ready = 1'b0; IR_data = 32'h289A8000;
    tick(); check("tmo_t0", {20'h0, strobes}, {20'h0, ST_T0});
    for (int i = 0; i < 15; i++) tick();
    check("tmo_last_t1", {20'h0, strobes}, {20'h0, ST_T1_N});
    check("tmo_no_err_yet", {31'h0, Bus_error}, 32'h0);
    tick(); check("tmo_halt", {20'h0, strobes}, {20'h0, ST_HALT});
            check("tmo_bus_error", {31'h0, Bus_error}, 32'h1);
            check("tmo_read", {31'h0, Read}, 32'h0);

    // Ra=9: illegal with 8 registers, legal with 16
    Reset = 1'b0; tick(); Reset = 1'b1;
    Mem_ready = 1'b1; IR_data = 32'h2C888000;
    tick(); tick(); tick(); tick(); tick();
    check("ra9_small_ill", {30'h0, s_Illegal_op, s_Halted}, 32'h3);
    check("ra9_big_legal", {30'h0, Illegal_op, Halted}, 32'h0);
    check("ra9_big_t4_rout", {16'h0, Rout}, 32'h0002);

    // nop stream: 4 cycles each, 4-bit counter wraps 15 -> 0
    Reset = 1'b0; tick(); Reset = 1'b1;
    IR_data = 32'hD0000000;
    tick();
    for (int i = 0; i < 15; i++) begin
      tick(); tick(); tick(); tick();
    end
    check("nop_t0_again", {20'h0, strobes}, {20'h0, ST_T0});
    check("nop_small_15", {28'h0, s_Instr_count}, 32'hF);
    tick(); tick(); tick(); tick();
    check("nop_small_wrap", {28'h0, s_Instr_count}, 32'h0);
    check("nop_big_16", {16'h0, Instr_count}, 32'h10);

    // halt opcode: Halted without Illegal_op
    IR_data = 32'hD8000000;
    tick(); tick(); tick(); tick();
    check("halt_op", {20'h0, strobes}, {20'h0, ST_HALT});
    check("halt_op_legal", {31'h0, Illegal_op}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
